branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, giving the PC/target width.
REQ-002 SHALL provide parameter NUM_ENTRIES, default 256, giving the direct-mapped entry count (power of 2, IDX_BITS = log2(NUM_ENTRIES)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port if_PC, input, DATA_WIDTH: fetch PC to look up.
REQ-006 SHALL have port if_pred, output, 1 bit: predict taken (hit AND counter MSB = 1).
REQ-007 SHALL have port if_hit, output, 1 bit: valid entry whose tag matches if_PC.
REQ-008 SHALL have port if_pred_PC_target, output, DATA_WIDTH: stored target on hit, else 0.
REQ-009 SHALL have port if_next_PC, output, DATA_WIDTH: if_pred ? if_pred_PC_target : if_PC + 4.
REQ-010 SHALL have port ex_update, input, 1 bit: a resolved branch/jump is presented this cycle.
REQ-011 SHALL have port ex_PC, input, DATA_WIDTH: PC of the resolved branch.
REQ-012 SHALL have port ex_taken, input, 1 bit: actual outcome.
REQ-013 SHALL have port ex_target, input, DATA_WIDTH: actual taken target.

Function
REQ-014 SHALL form index = PC[IDX_BITS+1:2] and tag = PC[DATA_WIDTH-1:IDX_BITS+2]; PC[1:0] ignored.
REQ-015 SHALL give each entry a valid bit, tag, target, and 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 SHALL perform lookup combinationally: zero-cycle latency from if_PC to all if_* outputs.
REQ-017 SHALL, on ex_update with a hit and ex_taken=1, increment the counter (saturating at 11) and overwrite the target with ex_target.
REQ-018 SHALL, on ex_update with a hit and ex_taken=0, decrement the counter (saturating at 00) and leave the target unchanged.
REQ-019 SHALL, on ex_update with a miss and ex_taken=1, allocate/replace the entry: valid=1, new tag, target=ex_target, counter=10.
REQ-020 SHALL, on ex_update with a miss and ex_taken=0, leave the table unchanged.
REQ-021 SHALL make updates visible on the cycle after the clock edge; a same-cycle lookup of the index being updated returns the pre-update contents.
REQ-022 SHALL compute if_PC + 4 modulo 2^DATA_WIDTH (wrap-around, no carry out).
REQ-023 SHALL treat ex_update=0 as no state change, whatever the other ex_* values are.

Reset
REQ-024 SHALL, when rstn=0 at a rising edge, clear every valid bit and set every counter to 01; tags and targets need not be reset.
REQ-025 SHALL, during and after reset, show if_hit=0, if_pred=0, if_pred_PC_target=0 and if_next_PC=if_PC+4 until a later allocation.
REQ-026 SHALL give reset priority over a simultaneous ex_update; that update is discarded.

Structure
REQ-027 SHALL place the counter encodings (SNT/WNT/WT/ST) and the allocation value in a shared package used by the BTB and the EX-stage resolution logic.
REQ-028 SHALL implement the saturating update as one sub-module, sat_counter2 (inputs: current state, taken; output: next state).
REQ-029 SHALL be instantiated in the IF stage, driving the if_pred, if_hit and if_pred_PC_target inputs of the IF/ID register and the PC mux.

Verification
REQ-030 SHALL cover cold lookup: after reset, if_PC=0x0000_1000 -> if_hit=0, if_pred=0, if_next_PC=0x0000_1004.
REQ-031 SHALL cover allocation: ex_update, ex_PC=0x1000, taken, target 0x2000; next cycle if_PC=0x1000 -> hit=1, pred=1, target=0x2000, next_PC=0x2000.
REQ-032 SHALL cover hysteresis: from 10, one not-taken gives 01 (pred=0, hit=1); two taken give 11; three not-taken give 00, and a fourth stays 00.
REQ-033 SHALL cover aliasing: allocate 0x1000, then a taken update at 0x1400 (same index, NUM_ENTRIES=256) -> lookup 0x1000 misses and 0x1400 hits.
REQ-034 SHALL cover same-cycle collision: lookup and update of the same index together -> that cycle shows old contents, the next cycle shows new ones.
REQ-035 SHALL cover reset mid-operation: rstn=0 with ex_update=1 on a populated table -> all lookups miss afterwards, and the update is discarded.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer and the EX-stage
// resolution logic. It holds the 2-bit predictor counter encodings and
// the counter values used at reset and when a new entry is allocated.
package branch_target_buffer_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  // A freshly allocated entry starts weakly taken.
  localparam ctr_e CTR_ALLOC = CTR_WT;
  // Counter value after reset.
  localparam ctr_e CTR_RESET = CTR_WNT;

  // The counter MSB is the taken prediction.
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating predictor counter.
// Ports:
//   state_i - current counter value (SNT/WNT/WT/ST)
//   taken_i - resolved branch outcome
//   next_o  - counter value after the update (saturates at SNT and ST)
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  // Step one position toward ST on taken, toward SNT on not taken.
  always_comb begin
    next_o = state_i;
    case (state_i)
      CTR_SNT: next_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: next_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  next_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  next_o = taken_i ? CTR_ST  : CTR_WT;
      default: next_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating predictors,
// used in the IF stage to steer the PC mux and feed the IF/ID register.
// Ports:
//   clk, rstn          - clock and synchronous active-low reset
//   if_PC              - fetch PC to look up (combinational lookup)
//   if_hit             - valid entry whose tag matches if_PC
//   if_pred            - predict taken (hit and counter MSB set)
//   if_pred_PC_target  - stored target on hit, else 0
//   if_next_PC         - if_pred ? target : if_PC + 4 (wraps)
//   ex_update          - resolved branch presented this cycle
//   ex_PC, ex_taken    - PC and outcome of the resolved branch
//   ex_target          - resolved taken target
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] if_PC,
  output logic                  if_pred,
  output logic                  if_hit,
  output logic [DATA_WIDTH-1:0] if_pred_PC_target,
  output logic [DATA_WIDTH-1:0] if_next_PC,
  input  logic                  ex_update,
  input  logic [DATA_WIDTH-1:0] ex_PC,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target
);

  localparam int IDX_BITS = $clog2(NUM_ENTRIES);
  localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

  logic                  valid_q  [NUM_ENTRIES];
  logic [1:0]            ctr_q    [NUM_ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [NUM_ENTRIES];

  logic [IDX_BITS-1:0]   if_idx_s;
  logic [TAG_BITS-1:0]   if_tag_s;
  logic [IDX_BITS-1:0]   ex_idx_s;
  logic [TAG_BITS-1:0]   ex_tag_s;
  logic                  ex_hit_s;
  logic [1:0]            ctr_sat_s;
  logic [1:0]            ctr_d;
  logic                  ctr_wr_s;
  logic                  tgt_wr_s;

  // Instruction alignment bits never take part in indexing or tagging.
  logic unused_align_bits_s;
  assign unused_align_bits_s = ^{if_PC[1:0], ex_PC[1:0]};

  // Fetch-side lookup; reads the table as it stood before this edge.
  always_comb begin
    if_idx_s = if_PC[IDX_BITS+1:2];
    if_tag_s = if_PC[DATA_WIDTH-1:IDX_BITS+2];
    if_hit   = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    if_pred  = if_hit && ctr_predicts_taken(ctr_q[if_idx_s]);
    if (if_hit) begin
      if_pred_PC_target = target_q[if_idx_s];
    end else begin
      if_pred_PC_target = '0;
    end
    if (if_pred) begin
      if_next_PC = if_pred_PC_target;
    end else begin
      if_next_PC = if_PC + PC_STEP;
    end
  end

  sat_counter2 u_sat_counter2 (
    .state_i (ctr_q[ex_idx_s]),
    .taken_i (ex_taken),
    .next_o  (ctr_sat_s)
  );

  // EX-side update decode: hits train the counter, taken misses allocate.
  always_comb begin
    ex_idx_s = ex_PC[IDX_BITS+1:2];
    ex_tag_s = ex_PC[DATA_WIDTH-1:IDX_BITS+2];
    ex_hit_s = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
    if (ex_hit_s) begin
      ctr_d = ctr_sat_s;
    end else begin
      ctr_d = CTR_ALLOC;
    end
    ctr_wr_s = ex_update && (ex_hit_s || ex_taken);
    // Any taken update rewrites tag and target; on a hit the tag is unchanged.
    tgt_wr_s = ex_update && ex_taken;
  end

  // Valid bits and counters; reset wins over a simultaneous update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (ctr_wr_s) begin
      valid_q[ex_idx_s] <= 1'b1;
      ctr_q[ex_idx_s]   <= ctr_d;
    end else begin
      valid_q[ex_idx_s] <= valid_q[ex_idx_s];
    end
  end

  // Tags and targets carry no reset; they are masked by the valid bit.
  always_ff @(posedge clk) begin
    if (rstn && tgt_wr_s) begin
      tag_q[ex_idx_s]    <= ex_tag_s;
      target_q[ex_idx_s] <= ex_target;
    end else begin
      target_q[ex_idx_s] <= target_q[ex_idx_s];
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a stimulus process drives
// lookups/updates and pushes the reference model's expected lookup result;
// a monitor process pops and compares on the falling clock edge.
module tb_branch_target_buffer;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_PC;
  logic        if_pred;
  logic        if_hit;
  logic [31:0] if_pred_PC_target;
  logic [31:0] if_next_PC;
  logic        ex_update;
  logic [31:0] ex_PC;
  logic        ex_taken;
  logic [31:0] ex_target;

  branch_target_buffer #(.DATA_WIDTH(32), .NUM_ENTRIES(N)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .if_PC             (if_PC),
    .if_pred           (if_pred),
    .if_hit            (if_hit),
    .if_pred_PC_target (if_pred_PC_target),
    .if_next_PC        (if_next_PC),
    .ex_update         (ex_update),
    .ex_PC             (ex_PC),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] nxt;
  } exp_t;

  exp_t q[$];
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference model: per set, remember the PC bits above the index, the
  // target and a counter kept as an integer 0..3.
  bit          m_valid [N];
  logic [31:0] m_upper [N];
  logic [31:0] m_tgt   [N];
  int          m_cnt   [N];

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int   s;
    s      = set_of(pc);
    e.pc   = pc;
    e.hit  = m_valid[s] && (m_upper[s] == (pc >> 10));
    e.pred = e.hit && (m_cnt[s] >= 2);
    e.tgt  = e.hit ? m_tgt[s] : 32'd0;
    e.nxt  = e.pred ? e.tgt : pc + 32'd4;
    return e;
  endfunction

  task automatic model_edge();
    int s;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
    end else if (ex_update) begin
      s = set_of(ex_PC);
      if (m_valid[s] && m_upper[s] == (ex_PC >> 10)) begin
        if (ex_taken) begin
          m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = ex_target;
        end else begin
          m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (ex_taken) begin
        m_valid[s] = 1'b1;
        m_upper[s] = ex_PC >> 10;
        m_tgt[s]   = ex_target;
        m_cnt[s]   = 2;
      end
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, advance, update model.
  task automatic step(input logic rst_v, input logic [31:0] pc, input logic upd,
                      input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                      input logic chk);
    rstn      = rst_v;
    if_PC     = pc;
    ex_update = upd;
    ex_PC     = epc;
    ex_taken  = tk;
    ex_target = tgt;
    if (chk) q.push_back(model_lookup(pc));
    chk_en = chk;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic upd(input logic [31:0] lpc, input logic [31:0] epc,
                     input logic tk, input logic [31:0] tgt);
    step(1'b1, lpc, 1'b1, epc, tk, tgt, 1'b1);
  endtask

  // Monitor: compare the DUT's combinational lookup against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
      end else begin
        e = q.pop_front();
        if (if_hit !== e.hit) begin
          failures++;
          $display("FAIL hit pc=%h: got %b want %b", e.pc, if_hit, e.hit);
        end
        checks++;
        if (if_pred !== e.pred) begin
          failures++;
          $display("FAIL pred pc=%h: got %b want %b", e.pc, if_pred, e.pred);
        end
        checks++;
        if (if_pred_PC_target !== e.tgt) begin
          failures++;
          $display("FAIL target pc=%h: got %h want %h", e.pc, if_pred_PC_target, e.tgt);
        end
        checks++;
        if (if_next_PC !== e.nxt) begin
          failures++;
          $display("FAIL next_pc pc=%h: got %h want %h", e.pc, if_next_PC, e.nxt);
        end
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] upper;
    case ($urandom_range(0, 4))
      0:       upper = 32'd0;
      1:       upper = 32'd1;
      2:       upper = 32'd5;
      3:       upper = 32'd2;
      default: upper = 32'h003F_FFFF;
    endcase
    return (upper << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    rstn = 1'b0; if_PC = 32'd0; ex_update = 1'b0;
    ex_PC = 32'd0; ex_taken = 1'b0; ex_target = 32'd0;
    @(posedge clk);
    #1;
    // Reset: first cycle is unchecked (table undefined), then during reset.
    step(1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b0);
    step(1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1);
    // Cold lookup.
    look(32'h0000_1000);
    // Allocation, with a same-cycle lookup of the same set (old contents).
    upd(32'h0000_1000, 32'h0000_1000, 1'b1, 32'h0000_2000);
    look(32'h0000_1000);
    // Hysteresis: NT, T, T, NT, NT, NT, NT with a lookup after each.
    upd(32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0000_9999); look(32'h0000_1000);
    upd(32'h0000_1000, 32'h0000_1000, 1'b1, 32'h0000_2000); look(32'h0000_1000);
    upd(32'h0000_1000, 32'h0000_1000, 1'b1, 32'h0000_2000); look(32'h0000_1000);
    for (int k = 0; k < 4; k++) begin
      upd(32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0000_7777); look(32'h0000_1000);
    end
    // Not-taken miss leaves the table alone; ex_update=0 ignores ex_* values.
    upd(32'h0000_3000, 32'h0000_3000, 1'b0, 32'h0000_4444); look(32'h0000_3000);
    step(1'b1, 32'h0000_1000, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_5555, 1'b1);
    look(32'h0000_3000);
    // Aliasing: 0x1400 shares the set of 0x1000.
    upd(32'h0000_1000, 32'h0000_1400, 1'b1, 32'h0000_3000);
    look(32'h0000_1000);
    look(32'h0000_1400);
    // PC + 4 wraps to zero.
    look(32'hFFFF_FFFC);
    look(32'hFFFF_FFFE);
    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, rand_pc(),
           1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
           $urandom, 1'b1);
    end
    // Reset mid-operation on a populated table, with a discarded update.
    upd(32'h0000_0000, 32'h0000_1000, 1'b1, 32'h0000_2000);
    upd(32'h0000_0000, 32'h0000_1004, 1'b1, 32'h0000_2004);
    look(32'h0000_1000);
    step(1'b0, 32'h0000_1000, 1'b1, 32'h0000_1008, 1'b1, 32'h0000_2008, 1'b1);
    look(32'h0000_1000);
    look(32'h0000_1004);
    look(32'h0000_1008);
    chk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
